// File: rtl/rip_fifo_pkg.sv
// Shared constants, ratio helpers and FSM state type for the FIFO read-side
// unpacker (and any future pack counterpart).
package rip_fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 128;
    localparam int BUS_WIDTH       = 32;

    typedef enum logic {
        EMPTY  = 1'b0,
        STREAM = 1'b1
    } unpack_state_e;

    function automatic int beat_ratio(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // Beat index needs at least one bit even when only two beats exist.
    function automatic int beat_idx_w(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/rip_fifo_unpack.sv
// Pops one wide entry from a show-ahead FIFO and serializes it into OUT_WIDTH
// beats on a valid/ready stream, one beat per cycle with no inter-entry bubble.
module rip_fifo_unpack
    import rip_fifo_pkg::*;
#(
    parameter int IN_WIDTH  = FIFO_DATA_WIDTH,
    parameter int OUT_WIDTH = BUS_WIDTH,
    parameter int MSB_FIRST = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_r_en,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic [15:0]          entry_count
);

    localparam int RATIO = beat_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int IDX_W = beat_idx_w(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if (RATIO < 2 || RATIO * OUT_WIDTH != IN_WIDTH) begin : g_bad_ratio
        $error("rip_fifo_unpack: IN_WIDTH must be an integer multiple (>=2) of OUT_WIDTH");
    end

    unpack_state_e        state_q, state_d;
    logic [IN_WIDTH-1:0]  hold_q, hold_d;
    logic [IDX_W-1:0]     beat_idx_q, beat_idx_d;
    logic [15:0]          count_q, count_d;
    logic                 hold_valid;
    logic                 accept;
    logic                 last_accept;
    logic                 pop;
    logic [OUT_WIDTH-1:0] beat_w [RATIO];

    assign hold_valid  = (state_q == STREAM);
    assign accept      = hold_valid & out_ready;
    assign last_accept = accept & (beat_idx_q == LAST_IDX);
    // Reloading on the last accepted beat is what keeps entries back-to-back.
    assign pop         = !flush & !fifo_empty & (!hold_valid | last_accept);

    for (genvar k = 0; k < RATIO; k++) begin : g_beat
        localparam int SEL = (MSB_FIRST != 0) ? (RATIO - 1 - k) : k;
        assign beat_w[k] = hold_q[SEL*OUT_WIDTH +: OUT_WIDTH];
    end

    assign fifo_r_en   = pop;
    assign out_valid   = hold_valid;
    assign out_data    = beat_w[beat_idx_q];
    assign out_last    = hold_valid & (beat_idx_q == LAST_IDX);
    assign entry_count = count_q;

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        beat_idx_d = beat_idx_q;
        count_d    = count_q;
        if (flush) begin
            state_d    = EMPTY;
            beat_idx_d = '0;
            count_d    = '0;
        end else if (pop) begin
            state_d    = STREAM;
            hold_d     = fifo_data;
            beat_idx_d = '0;
            count_d    = count_q + 16'd1;
        end else if (accept) begin
            if (last_accept) begin
                state_d = EMPTY;
            end else begin
                beat_idx_d = beat_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            hold_q     <= '0;
            beat_idx_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            beat_idx_q <= beat_idx_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_rip_fifo_unpack.sv
// Bench for rip_fifo_unpack: LSB-first and MSB-first instances share stimulus,
// checked against a queue-based stream model plus constant beat tables.
module tb_rip_fifo_unpack;

    localparam int IW = 128;
    localparam int OW = 32;
    localparam int R  = IW / OW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          fifo_empty;
    logic          out_ready;
    logic [IW-1:0] fifo_data;
    logic          r_en0, r_en1, v0, v1, l0, l1;
    logic [OW-1:0] d0, d1;
    logic [15:0]   c0, c1;

    always #5 clk = ~clk;

    rip_fifo_unpack #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_r_en(r_en0), .out_data(d0),
        .out_valid(v0), .out_ready(out_ready), .out_last(l0), .entry_count(c0)
    );

    rip_fifo_unpack #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .MSB_FIRST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_r_en(r_en1), .out_data(d1),
        .out_valid(v1), .out_ready(out_ready), .out_last(l1), .entry_count(c1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: FIFO contents, and the beats still owed for the held entry.
    logic [IW-1:0] fifo_q[$];
    logic [OW-1:0] cur0_q[$];
    logic [OW-1:0] cur1_q[$];
    logic [15:0]   exp_cnt = '0;

    // Accepted beats as seen at the DUT outputs.
    logic [OW-1:0] cap0[$];
    logic [OW-1:0] cap1[$];
    logic          capl0[$];
    logic          capl1[$];
    int            dut_pops = 0;

    typedef struct {
        logic [IW-1:0] entry;
        logic [OW-1:0] beat [R];
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic push_entry(input logic [IW-1:0] e);
        fifo_q.push_back(e);
        drive_fifo();
    endtask

    task automatic load_model(input logic [IW-1:0] e);
        cur0_q.delete();
        cur1_q.delete();
        for (int k = 0; k < R; k++) begin
            cur0_q.push_back(e[k*OW +: OW]);
            cur1_q.push_back(e[(R-1-k)*OW +: OW]);
        end
    endtask

    task automatic clear_capture();
        cap0.delete(); cap1.delete(); capl0.delete(); capl1.delete();
        dut_pops = 0;
    endtask

    // One clock: inputs already applied; check at negedge, advance model at posedge.
    task automatic step();
        bit ev, el, ep;
        ev = (cur0_q.size() != 0);
        el = (cur0_q.size() == 1);
        ep = !flush && (fifo_q.size() != 0) && (!ev || (out_ready && el));
        @(negedge clk);
        chk("out_valid0", v0, ev);
        chk("out_valid1", v1, ev);
        chk("out_last0", l0, el);
        chk("out_last1", l1, el);
        chk("fifo_r_en0", r_en0, ep);
        chk("fifo_r_en1", r_en1, ep);
        chk("entry_count0", c0, exp_cnt);
        chk("entry_count1", c1, exp_cnt);
        if (ev) begin
            chk("out_data0", d0, cur0_q[0]);
            chk("out_data1", d1, cur1_q[0]);
        end
        if (v0 && out_ready) begin cap0.push_back(d0); capl0.push_back(l0); end
        if (v1 && out_ready) begin cap1.push_back(d1); capl1.push_back(l1); end
        if (r_en0) dut_pops++;
        @(posedge clk);
        if (flush) begin
            cur0_q.delete();
            cur1_q.delete();
            exp_cnt = '0;
        end else if (ep) begin
            load_model(fifo_q.pop_front());
            exp_cnt = exp_cnt + 16'd1;
        end else if (ev && out_ready) begin
            void'(cur0_q.pop_front());
            void'(cur1_q.pop_front());
        end
        #1 drive_fifo();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IW-1:0] e1, e2;
        logic [15:0]   base;

        vecs[0].entry = 128'h44444444_33333333_22222222_11111111;
        vecs[0].beat  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        vecs[1].entry = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        vecs[1].beat  = '{32'h89ABCDEF, 32'h01234567, 32'hCAFEF00D, 32'hDEADBEEF};
        vecs[2].entry = 128'hFFFFFFFF_00000000_80000001_7FFFFFFE;
        vecs[2].beat  = '{32'h7FFFFFFE, 32'h80000001, 32'h00000000, 32'hFFFFFFFF};

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_fifo();
        #12;
        chk("rst_valid", v0, 1'b0);
        chk("rst_last", l0, 1'b0);
        chk("rst_data", d0, 32'h0);
        chk("rst_r_en", r_en0, 1'b0);
        chk("rst_count", c0, 16'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle with an empty FIFO: nothing may be popped.
        out_ready = 1'b1;
        clear_capture();
        repeat (10) step();
        chk("idle_pops", dut_pops, 0);

        // Single entries, both beat orders, against fixed tables.
        for (int v = 0; v < 3; v++) begin
            clear_capture();
            push_entry(vecs[v].entry);
            repeat (6) step();
            chk("tbl_pops", dut_pops, 1);
            chk("tbl_size0", cap0.size(), R);
            chk("tbl_size1", cap1.size(), R);
            if (cap0.size() == R && cap1.size() == R) begin
                for (int k = 0; k < R; k++) begin
                    chk("tbl_lsb_beat", cap0[k], vecs[v].beat[k]);
                    chk("tbl_msb_beat", cap1[k], vecs[v].beat[R-1-k]);
                    chk("tbl_lsb_last", capl0[k], (k == R-1));
                    chk("tbl_msb_last", capl1[k], (k == R-1));
                end
            end
        end
        chk("tbl_count", c0, 16'd3);

        // Three queued entries stream back-to-back.
        clear_capture();
        base = exp_cnt;
        for (int i = 0; i < 3; i++) push_entry({$urandom, $urandom, $urandom, $urandom});
        repeat (14) step();
        chk("b2b_pops", dut_pops, 3);
        chk("b2b_beats", cap0.size(), 12);
        chk("b2b_count", c0, base + 16'd3);

        // Backpressure pattern 1,0,0 repeating.
        clear_capture();
        for (int i = 0; i < 2; i++) push_entry({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 30; i++) begin
            out_ready = (i % 3 == 0);
            step();
        end
        chk("bp_pops", dut_pops, 2);
        chk("bp_beats", cap0.size(), 8);

        // Flush mid-entry with another entry waiting.
        out_ready = 1'b1;
        e1 = {$urandom, $urandom, $urandom, $urandom};
        e2 = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F00DCAFE;
        push_entry(e1);
        push_entry(e2);
        repeat (3) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", v0, 1'b0);
        chk("flush_count", c0, 16'h0);
        step();
        chk("refill_valid", v0, 1'b1);
        chk("refill_count", c0, 16'd1);
        chk("refill_data0", d0, 32'hF00DCAFE);
        chk("refill_data1", d1, 32'hA5A5A5A5);
        repeat (5) step();

        // Asynchronous reset in the middle of an entry.
        push_entry(vecs[0].entry);
        repeat (2) step();
        chk("pre_rst_valid", v0, 1'b1);
        #1 rst_n = 1'b0;
        fifo_q.delete();
        cur0_q.delete();
        cur1_q.delete();
        exp_cnt = '0;
        drive_fifo();
        #1;
        chk("arst_valid0", v0, 1'b0);
        chk("arst_valid1", v1, 1'b0);
        chk("arst_last", l0, 1'b0);
        chk("arst_data", d0, 32'h0);
        chk("arst_count", c0, 16'h0);
        chk("arst_r_en", r_en0, 1'b0);
        #1 rst_n = 1'b1;
        repeat (3) step();

        // Randomized traffic, backpressure and occasional flush.
        for (int i = 0; i < 600; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 2) == 0 && fifo_q.size() < 4)
                push_entry({$urandom, $urandom, $urandom, $urandom});
            step();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
